// File: rtl/assoc_cache.sv
// assoc_cache: SETS x K set-associative write-back cache with per-set CLOCK replacement.
module assoc_cache #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K          = 2,
  parameter int SETS       = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LINE_WIDTH-1:0] in_val,
  input  logic                  read,
  input  logic                  write,
  input  logic                  fill,
  input  logic                  invalidate,
  output logic                  ready,
  output logic                  done,
  output logic                  hit,
  output logic [LINE_WIDTH-1:0] out_val,
  output logic                  evict_valid,
  output logic [ADDR_WIDTH-1:0] evict_addr,
  output logic [LINE_WIDTH-1:0] evict_val
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - IW;
  localparam int PW = $clog2(K);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;
  logic [K-1:0] valid_q [SETS];
  logic [K-1:0] ref_q [SETS];
  logic [K-1:0] dirty_q [SETS];
  logic [TW-1:0] tag_q [SETS][K];
  logic [LINE_WIDTH-1:0] data_q [SETS][K];
  logic [PW-1:0] ptr_q [SETS];
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [LINE_WIDTH-1:0] cap_val;
  logic cap_wr;
  logic [IW-1:0] idx, cidx;
  logic [TW-1:0] tag, ctag;
  logic [PW-1:0] p, p_nxt, hit_w, free_w;
  logic hit_any, free_any, accept, op_inv, op_wr, op_fill;
  assign ready   = state == IDLE;
  assign idx     = in_addr[IW-1:0];
  assign tag     = in_addr[ADDR_WIDTH-1:IW];
  assign cidx    = cap_addr[IW-1:0];
  assign ctag    = cap_addr[ADDR_WIDTH-1:IW];
  assign p       = ptr_q[cidx];
  assign p_nxt   = (p == PW'(K - 1)) ? '0 : p + 1'b1;
  assign op_inv  = invalidate;
  assign op_wr   = write & ~invalidate;
  assign op_fill = fill & ~invalidate & ~write;
  assign accept  = ready & enable & (read | write | fill | invalidate);
  // descending scan so the lowest-index match/free way wins
  always_comb begin
    hit_any  = 1'b0;
    hit_w    = '0;
    free_any = 1'b0;
    free_w   = '0;
    for (int w = K - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_w   = PW'(w);
      end
      if (!valid_q[idx][w]) begin
        free_any = 1'b1;
        free_w   = PW'(w);
      end
    end
    state_nxt = state;
    if (state == IDLE && accept && (op_wr || op_fill) && !hit_any && !free_any) state_nxt = SWEEP;
    else if (state == SWEEP && !ref_q[cidx][p]) state_nxt = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ref_q[s]   <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < K; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
      cap_addr    <= '0;
      cap_val     <= '0;
      cap_wr      <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      out_val     <= '0;
      evict_valid <= 1'b0;
      evict_addr  <= '0;
      evict_val   <= '0;
    end else begin
      done        <= 1'b0;
      evict_valid <= 1'b0;
      if (accept) begin
        cap_addr <= in_addr;
        cap_val  <= in_val;
        cap_wr   <= op_wr;
        if (op_inv) begin
          done <= 1'b1;
          hit  <= hit_any;
          if (hit_any) begin
            valid_q[idx][hit_w] <= 1'b0;
            ref_q[idx][hit_w]   <= 1'b0;
            dirty_q[idx][hit_w] <= 1'b0;
            if (dirty_q[idx][hit_w]) begin
              evict_valid <= 1'b1;
              evict_addr  <= in_addr;
              evict_val   <= data_q[idx][hit_w];
            end
          end
        end else if (op_wr || op_fill) begin
          if (hit_any) begin
            done <= 1'b1;
            hit  <= 1'b1;
            if (op_wr) begin
              data_q[idx][hit_w]  <= in_val;
              ref_q[idx][hit_w]   <= 1'b1;
              dirty_q[idx][hit_w] <= 1'b1;
            end
          end else if (free_any) begin
            done                 <= 1'b1;
            hit                  <= 1'b0;
            valid_q[idx][free_w] <= 1'b1;
            ref_q[idx][free_w]   <= 1'b1;
            dirty_q[idx][free_w] <= op_wr;
            tag_q[idx][free_w]   <= tag;
            data_q[idx][free_w]  <= in_val;
          end
        end else begin
          done <= 1'b1;
          hit  <= hit_any;
          if (hit_any) begin
            out_val           <= data_q[idx][hit_w];
            ref_q[idx][hit_w] <= 1'b1;
          end
        end
      end else if (state == SWEEP) begin
        ptr_q[cidx] <= p_nxt;
        if (ref_q[cidx][p]) ref_q[cidx][p] <= 1'b0;
        else begin
          if (dirty_q[cidx][p]) begin
            evict_valid <= 1'b1;
            evict_addr  <= {tag_q[cidx][p], cidx};
            evict_val   <= data_q[cidx][p];
          end
          valid_q[cidx][p] <= 1'b1;
          ref_q[cidx][p]   <= 1'b1;
          dirty_q[cidx][p] <= cap_wr;
          tag_q[cidx][p]   <= ctag;
          data_q[cidx][p]  <= cap_val;
          hit              <= 1'b0;
          done             <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed vector table plus a reset-during-sweep sequence for assoc_cache.
module tb_assoc_cache;
  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [7:0] in_addr = '0;
  logic [31:0] in_val = '0;
  logic read = 1'b0, write = 1'b0, fill = 1'b0, invalidate = 1'b0;
  logic ready, done, hit, evict_valid;
  logic [31:0] out_val, evict_val;
  logic [7:0] evict_addr;
  int checks = 0, errors = 0;
  localparam logic [3:0] R = 4'b0001, F = 4'b0010, W = 4'b0100, I = 4'b1000;
  typedef struct {
    logic        rst;
    logic [3:0]  ops;
    logic [7:0]  addr;
    logic [31:0] val;
    logic        e_hit;
    logic [31:0] e_out;
    int          e_lat;
    logic        e_ev;
    logic [7:0]  e_eaddr;
    logic [31:0] e_eval;
  } vec_t;
  localparam int NV = 32;
  vec_t vt [NV];
  assoc_cache dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_addr(in_addr), .in_val(in_val),
    .read(read), .write(write), .fill(fill), .invalidate(invalidate), .ready(ready), .done(done),
    .hit(hit), .out_val(out_val), .evict_valid(evict_valid), .evict_addr(evict_addr),
    .evict_val(evict_val)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_evict_valid", 64'(evict_valid), 64'd0);
    chk("rst_evict_addr", 64'(evict_addr), 64'd0);
    chk("rst_evict_val", 64'(evict_val), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  task automatic run(input logic [3:0] ops, input logic [7:0] a, input logic [31:0] d,
                     output int lat, output int evn, output logic [7:0] ea, output logic [31:0] ev,
                     output int rdy_lo);
    {invalidate, write, fill, read} = ops;
    enable = 1'b1;
    in_addr = a;
    in_val = d;
    @(posedge clock);
    #1;
    {invalidate, write, fill, read} = 4'b0;
    enable = 1'b0;
    in_addr = ~a;
    in_val = ~d;
    lat = 0;
    evn = 0;
    rdy_lo = 0;
    ea = '0;
    ev = '0;
    do begin
      @(negedge clock);
      lat++;
      if (evict_valid) begin
        evn++;
        ea = evict_addr;
        ev = evict_val;
      end
      if (!ready) rdy_lo++;
    end while (!done && lat < 20);
  endtask
  initial begin
    int lat, evn, rdy_lo;
    logic [7:0] ea;
    logic [31:0] ev;
    vt[0]  = '{1, R, 8'h10, 32'h0,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[1]  = '{0, W, 8'h10, 32'hDEADBEEF, 0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[2]  = '{0, R, 8'h10, 32'h0,        1, 32'hDEADBEEF, 1, 0, 8'h00, 32'h0};
    vt[3]  = '{1, W, 8'h00, 32'hA,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[4]  = '{0, W, 8'h04, 32'hB,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[5]  = '{0, W, 8'h08, 32'hC,        0, 32'h0,        4, 1, 8'h00, 32'hA};
    vt[6]  = '{0, R, 8'h08, 32'h0,        1, 32'hC,        1, 0, 8'h00, 32'h0};
    vt[7]  = '{0, R, 8'h04, 32'h0,        1, 32'hB,        1, 0, 8'h00, 32'h0};
    vt[8]  = '{0, F, 8'h0C, 32'hD,        0, 32'hB,        4, 1, 8'h04, 32'hB};
    vt[9]  = '{0, R, 8'h0C, 32'h0,        1, 32'hD,        1, 0, 8'h00, 32'h0};
    vt[10] = '{0, R, 8'h04, 32'h0,        0, 32'hD,        1, 0, 8'h00, 32'h0};
    vt[11] = '{1, F, 8'h20, 32'h5,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[12] = '{0, W, 8'h24, 32'h6,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[13] = '{0, F, 8'h28, 32'h7,        0, 32'h0,        4, 0, 8'h00, 32'h0};
    vt[14] = '{0, R, 8'h20, 32'h0,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[15] = '{0, R, 8'h24, 32'h0,        1, 32'h6,        1, 0, 8'h00, 32'h0};
    vt[16] = '{0, R, 8'h28, 32'h0,        1, 32'h7,        1, 0, 8'h00, 32'h0};
    vt[17] = '{0, W, 8'h11, 32'h55,       0, 32'h7,        1, 0, 8'h00, 32'h0};
    vt[18] = '{0, R, 8'h11, 32'h0,        1, 32'h55,       1, 0, 8'h00, 32'h0};
    vt[19] = '{0, R, 8'h01, 32'h0,        0, 32'h55,       1, 0, 8'h00, 32'h0};
    vt[20] = '{0, W, 8'h11, 32'h66,       1, 32'h55,       1, 0, 8'h00, 32'h0};
    vt[21] = '{0, R, 8'h11, 32'h0,        1, 32'h66,       1, 0, 8'h00, 32'h0};
    vt[22] = '{0, F, 8'h11, 32'h77,       1, 32'h66,       1, 0, 8'h00, 32'h0};
    vt[23] = '{0, R, 8'h11, 32'h0,        1, 32'h66,       1, 0, 8'h00, 32'h0};
    vt[24] = '{1, W, 8'h08, 32'hC,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[25] = '{0, I|R, 8'h08, 32'h0,      1, 32'h0,        1, 1, 8'h08, 32'hC};
    vt[26] = '{0, R, 8'h08, 32'h0,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[27] = '{0, I, 8'h30, 32'h0,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[28] = '{0, W|F, 8'h14, 32'h99,     0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[29] = '{0, I, 8'h14, 32'h0,        1, 32'h0,        1, 1, 8'h14, 32'h99};
    vt[30] = '{0, F, 8'h15, 32'h3,        0, 32'h0,        1, 0, 8'h00, 32'h0};
    vt[31] = '{0, I, 8'h15, 32'h0,        1, 32'h0,        1, 0, 8'h00, 32'h0};
    @(negedge clock);
    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst) do_reset();
      run(vt[i].ops, vt[i].addr, vt[i].val, lat, evn, ea, ev, rdy_lo);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].e_lat));
      chk($sformatf("v%0d_ready_low", i), 64'(rdy_lo), 64'(vt[i].e_lat - 1));
      chk($sformatf("v%0d_hit", i), 64'(hit), 64'(vt[i].e_hit));
      chk($sformatf("v%0d_out_val", i), 64'(out_val), 64'(vt[i].e_out));
      chk($sformatf("v%0d_evict_count", i), 64'(evn), 64'(vt[i].e_ev));
      if (vt[i].e_ev) begin
        chk($sformatf("v%0d_evict_addr", i), 64'(ea), 64'(vt[i].e_eaddr));
        chk($sformatf("v%0d_evict_val", i), 64'(ev), 64'(vt[i].e_eval));
      end
    end
    do_reset();
    run(W, 8'h00, 32'hA, lat, evn, ea, ev, rdy_lo);
    run(W, 8'h04, 32'hB, lat, evn, ea, ev, rdy_lo);
    write = 1'b1;
    enable = 1'b1;
    in_addr = 8'h08;
    in_val = 32'hC;
    @(posedge clock);
    #1;
    write = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    chk("sweep_ready_low", 64'(ready), 64'd0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_evict_valid", 64'(evict_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      logic [7:0] a;
      a = 8'(4 * j);
      run(R, a, 32'h0, lat, evn, ea, ev, rdy_lo);
      chk($sformatf("abort_read_%0h_hit", a), 64'(hit), 64'd0);
      chk($sformatf("abort_read_%0h_evict", a), 64'(evn), 64'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised successor to the single-set K-way cache set. Holds SETS sets of K ways, indexed by low address bits, with per-set CLOCK (second-chance) replacement.
- Adds dirty tracking, write-back eviction output, a clean fill path, and a ready/done handshake.
- Sits between a requester and backing memory. The memory controller consumes the evict_* outputs.

Parameters:
- ADDR_WIDTH, 8, address width in bits.
- LINE_WIDTH, 32, data width per line.
- K, 2, ways per set; K >= 2, need not be a power of two.
- SETS, 4, number of sets; power of two, SETS >= 2.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  request qualifier.
- in_addr  input  ADDR_WIDTH  request address; index = in_addr[log2(SETS)-1:0], tag = remaining upper bits.
- in_val  input  LINE_WIDTH  write/fill data.
- read  input  1  read request.
- write  input  1  write request; installs or updates a line as dirty.
- fill  input  1  fill request from memory; installs a line clean.
- invalidate  input  1  invalidate request.
- ready  output  1  high when a request can be accepted.
- done  output  1  one-cycle pulse when a request completes.
- hit  output  1  tag matched a valid line at lookup; valid with done.
- out_val  output  LINE_WIDTH  read data; valid with done when hit=1.
- evict_valid  output  1  one-cycle pulse: a dirty line left the cache.
- evict_addr  output  ADDR_WIDTH  address of the departing line, {tag, index}.
- evict_val  output  LINE_WIDTH  data of the departing line.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - ready=1; hit, done, evict_valid=0; out_val, evict_addr, evict_val=0.
  - All lines invalid, with ref, dirty and tag cleared. All per-set CLOCK pointers = 0.
  - Reset during a sweep aborts it: no install, no evict.
- Acceptance:
  - A request is accepted at a posedge when ready=1, enable=1 and at least one op bit is high.
  - Priority: invalidate > write > fill > read. Only the winning op executes.
  - in_addr, in_val and the op are captured at acceptance and ignored afterwards.
- States: IDLE (ready=1) and SWEEP (ready=0).
- Single-edge ops: outputs update on the accepting edge; done=1 for the following cycle.
  - read hit: hit=1, out_val=line value, ref=1.
  - read miss: hit=0, out_val unchanged.
  - write hit: value replaced, ref=1, dirty=1, hit=1.
  - fill hit: no change to the line, hit=1.
  - invalidate hit: line made invalid, ref=0, hit=1. If the line was dirty, evict_valid pulses with its addr/val.
  - invalidate miss: hit=0, no evict.
  - write/fill miss with an invalid way in the set: install in the lowest-index invalid way, ref=1, dirty=(op==write), hit=0. Pointer unchanged.
- Write/fill miss with the set full: transition to SWEEP.
- SWEEP: one way examined per edge, the way at the set's pointer p.
  - If ref[p]=1: clear ref[p]; p advances.
  - If ref[p]=0: victim.
    - If the victim is dirty, evict_valid pulses with the victim's addr/val on the same edge.
    - Install the captured line at p: ref=1, dirty per op.
    - p advances; hit=0; done pulses; return to IDLE.
  - Pointer advance is p+1, wrapping from K-1 to 0. Only the addressed set's pointer moves.
  - Worst-case SWEEP length is K+1 edges.
- done, evict_valid: high exactly one cycle, otherwise 0.
- hit/out_val: hold their values until the next completion.
- enable is not required to stay high during SWEEP.

Test Plan (defaults: K=2, SETS=4; set 0 = addresses 0x00, 0x04, 0x08, 0x0C):
- Reset, read 0x10 -> done 1 cycle after accept, hit=0, out_val=0, evict_valid never high.
- write 0x10=0xDEADBEEF, then read 0x10 -> write completes in 1 cycle with hit=0; read returns hit=1, out_val=0xDEADBEEF.
- write 0x00=0xA, write 0x04=0xB, write 0x08=0xC -> third write:
  - ready=0 for 3 edges;
  - edge 1 clears way0 ref, edge 2 clears way1 ref, edge 3 evicts way0;
  - evict_valid=1 with evict_addr=0x00, evict_val=0xA; done pulses; read 0x08 hits with 0xC.
- Continue (p=1, way1=0x04 ref=0), read 0x04, then fill 0x0C=0xD -> sweep takes 3 edges:
  - way1 ref cleared, then way0 ref cleared, then way1 (0x04) evicted dirty with evict_val=0xB;
  - without the read, way1 is evicted on edge 1.
- fill 0x20=0x5 into empty set, then write 0x24, then fill 0x28 -> 0x20 chosen as victim, evict_valid stays 0 (clean line).
- Assert read and invalidate together on dirty 0x08 -> invalidate wins:
  - hit=1, evict_valid with 0x08/0xC; subsequent read 0x08 gives hit=0.
  - invalidate 0x30 (absent) -> hit=0, no evict.
- Drop reset_n on SWEEP edge 2 -> immediately ready=1, done=0, evict_valid=0; after release, read of every earlier address misses.
